// File: rtl/seq_div_16x8_pkg.sv
// Shared types and constants for the sequential 16/8 restoring divider.
// Holds the control state encoding and the width-derived constants.
package seq_div_16x8_pkg;

  localparam int DW = 8;
  localparam int ITER = 2 * DW;
  localparam logic [2*DW-1:0] DIV0_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_div_16x8_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it does not go negative.
module div_step #(
  parameter int DW = 8
) (
  input  logic [DW:0]   rem_in,
  input  logic          bit_in,
  input  logic [DW-1:0] divisor,
  output logic [DW:0]   rem_out,
  output logic          q_bit
);

  logic [DW+1:0] shifted;
  logic [DW:0]   diff;

  // One extra bit above the partial remainder so the compare can never wrap.
  assign shifted = {rem_in, bit_in};
  assign q_bit   = (shifted >= {2'b00, divisor});
  assign diff    = shifted[DW:0] - {1'b0, divisor};
  assign rem_out = q_bit ? diff : shifted[DW:0];

endmodule

// File: rtl/seq_div_16x8.sv
// Sequential unsigned 2*DW / DW divider: IDLE accepts an operand pair, RUN
// retires one quotient bit per cycle MSB first, DONE holds the result.
module seq_div_16x8 #(
  parameter int DW = seq_div_16x8_pkg::DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*DW-1:0]   dividend,
  input  logic [DW-1:0]     divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*DW-1:0]   quotient,
  output logic [DW-1:0]     remainder,
  output logic              div_by_zero
);
  import seq_div_16x8_pkg::*;

  localparam int NQ = 2 * DW;
  localparam int CW = $clog2(NQ);
  localparam logic [CW-1:0] CNT_LOAD = CW'(NQ - 1);

  state_t state_reg;
  state_t state_next;

  logic [CW-1:0] cnt_reg;
  logic [NQ-1:0] work_reg;
  logic [DW:0]   prem_reg;
  logic [DW-1:0] dvs_reg;
  logic [NQ-1:0] quot_reg;
  logic [DW-1:0] rem_reg;
  logic          dbz_reg;

  logic [DW:0]   step_rem;
  logic          step_q;
  logic [NQ-1:0] work_next;

  div_step #(.DW(DW)) u_step (
    .rem_in  (prem_reg),
    .bit_in  (work_reg[NQ-1]),
    .divisor (dvs_reg),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Dividend bits leave at the top while quotient bits enter at the bottom,
  // so after the last step the register holds the full quotient.
  assign work_next = {work_reg[NQ-2:0], step_q};

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt_reg == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      work_reg <= '0;
      prem_reg <= '0;
      dvs_reg  <= '0;
      quot_reg <= '0;
      rem_reg  <= '0;
      dbz_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              quot_reg <= '1;
              rem_reg  <= dividend[DW-1:0];
              dbz_reg  <= 1'b1;
            end else begin
              work_reg <= dividend;
              dvs_reg  <= divisor;
              prem_reg <= '0;
              cnt_reg  <= CNT_LOAD;
            end
          end
        end
        RUN: begin
          work_reg <= work_next;
          prem_reg <= step_rem;
          if (cnt_reg == '0) begin
            quot_reg <= work_next;
            rem_reg  <= step_rem[DW-1:0];
            dbz_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient    = quot_reg;
  assign remainder   = rem_reg;
  assign div_by_zero = dbz_reg;

  // Handshake invariants: never ready and valid together, result frozen while stalled.
  a_excl: assert property (@(posedge clk) disable iff (rst) !(in_ready && out_valid));

  a_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(quotient) &&
                                   $stable(remainder) && $stable(div_by_zero)));

  a_run: assert property (@(posedge clk) disable iff (rst)
    (state_reg == RUN && cnt_reg != '0) |=> (state_reg == RUN));

endmodule

// File: tb/tb_seq_div_16x8.sv
// Scoreboard bench for seq_div_16x8: directed corner cases, a stall test, a
// mid-run reset and randomized back-to-back traffic against an arithmetic model.
module tb_seq_div_16x8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cycle = 0;
  int   n_txn = 0;
  bit   rand_ready = 1'b0;

  seq_div_16x8 #(.DW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Reference model: plain integer division, with the all-ones convention for /0.
  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 8'd0) begin
      e.q   = 16'hFFFF;
      e.r   = a[7:0];
      e.dbz = 1'b1;
      e.lat = 1;
    end else begin
      e.q   = 16'(int'(a) / int'(b));
      e.r   = 8'(int'(a) % int'(b));
      e.dbz = 1'b0;
      e.lat = 17;
    end
    e.acc = 0;
    return e;
  endfunction

  // Called at a falling edge; returns one cycle after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [7:0] b);
    int   t;
    exp_t e;
    t = 0;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("issue_wait_in_ready", {31'd0, in_ready}, 32'd1);
    if (in_ready) begin
      e = model(a, b);
      e.acc = cycle + 1;
      q_exp.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("wait_idle", {31'd0, in_ready}, 32'd1);
  endtask

  // Monitor: samples shortly after the falling edge so same-edge stimulus has settled.
  initial begin
    bit          seen;
    bit          post;
    logic [15:0] hq;
    logic [7:0]  hr;
    logic        hd;
    exp_t        e;
    seen = 1'b0;
    post = 1'b0;
    hq = '0;
    hr = '0;
    hd = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        seen = 1'b0;
        post = 1'b0;
      end else begin
        if (post) begin
          check("in_ready_after_release", {31'd0, in_ready}, 32'd1);
          post = 1'b0;
        end
        if (out_valid) begin
          check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
          if (!seen) begin
            if (q_exp.size() == 0) begin
              check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
              e = q_exp[0];
              check("quotient", {16'd0, quotient}, {16'd0, e.q});
              check("remainder", {24'd0, remainder}, {24'd0, e.r});
              check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
              check("latency", cycle - e.acc + 1, e.lat);
            end
            hq = quotient;
            hr = remainder;
            hd = div_by_zero;
            seen = 1'b1;
          end else begin
            check("hold_quotient", {16'd0, quotient}, {16'd0, hq});
            check("hold_remainder", {24'd0, remainder}, {24'd0, hr});
            check("hold_div_by_zero", {31'd0, div_by_zero}, {31'd0, hd});
          end
          if (out_ready) begin
            if (q_exp.size() > 0) begin
              e = q_exp.pop_front();
              n_txn++;
              $display("txn %0d: %0d / %0d -> q=%0d r=%0d dbz=%0d", n_txn, e.a, e.b,
                       quotient, remainder, div_by_zero);
            end
            seen = 1'b0;
            post = 1'b1;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rand_ready) out_ready = ($urandom_range(3) != 0);
  end

  initial begin
    #950000;
    n_fail++;
    $display("FAIL watchdog: time limit reached with %0d results pending, required 0", q_exp.size());
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Stimulus
  initial begin
    logic [15:0] a;
    logic [7:0]  b;
    int          t;

    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_quotient", {16'd0, quotient}, 32'd0);
    check("rst_remainder", {24'd0, remainder}, 32'd0);
    check("rst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    issue(16'd1000, 8'd7);
    issue(16'hFFFF, 8'd1);
    issue(16'hFFFF, 8'hFF);
    issue(16'd5, 8'd10);
    issue(16'h1234, 8'd0);
    issue(16'd0, 8'd3);

    // Stall in DONE while the input side keeps changing.
    wait_idle();
    out_ready = 1'b0;
    issue(16'hBEEF, 8'd13);
    t = 0;
    while (!out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("stall_result_arrives", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(1));
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Reset in the eighth RUN cycle discards the operation.
    wait_idle();
    issue(16'h4321, 8'd9);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    q_exp.delete();
    @(negedge clk);
    rst = 1'b0;
    check("midrun_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrun_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrun_rst_quotient", {16'd0, quotient}, 32'd0);
    check("midrun_rst_remainder", {24'd0, remainder}, 32'd0);
    check("midrun_rst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
    repeat (25) @(negedge clk);
    issue(16'd1000, 8'd7);

    // Randomized back-to-back traffic with random downstream back-pressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(9))
        0:       a = 16'd0;
        1:       a = 16'hFFFF;
        default: a = 16'($urandom);
      endcase
      case ($urandom_range(19))
        0, 1:    b = 8'd0;
        2, 3:    b = 8'hFF;
        4:       b = 8'd1;
        default: b = 8'($urandom);
      endcase
      issue(a, b);
    end

    t = 0;
    while (q_exp.size() > 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    check("drain_pending", q_exp.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
